csel_adder_pipe: RTL and testbench
==================================

Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 16-bit, 4-bit-block carry-select adder.
- Operand width, block size and pipeline depth are parameters; adds subtract mode, signed overflow flag and a valid/ready handshake with backpressure.
- Sits between operand registers and the result bus of the datapath ALU.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLK*STAGES.
- BLK, 4, carry-select block width in bits; each block holds two ripple adders (cin=0, cin=1) plus a carry-selected mux.
- STAGES, 2, register stages; each stage covers WIDTH/STAGES bits (a whole number of blocks); latency = STAGES cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry in (add mode only).
- sub  in  1  1 = a - b, 0 = a + b + c_in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of MSB (in sub mode, 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset: one clock; rst_n is asynchronous, active-low. While rst_n=0, all stage valid bits, out_valid, sum, c_out and ovf are 0. Datapath registers also clear to 0.
- Operand conditioning at acceptance:
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : c_in. c_in is ignored when sub=1.
- Advance condition: adv = !out_valid || out_ready. Also in_ready = adv, so in_ready is combinational from out_ready/out_valid.
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Stall rule: when adv=0, every pipeline register (data and valid) holds. sum/c_out/ovf stay stable while out_valid=1 and out_ready=0.
- When adv=1, all stages shift one step. Stage 0 loads the accepted operand; if no input transfer occurs, stage 0 loads a bubble (valid=0). Bubbles propagate; no compaction.
- Stage k (0..STAGES-1):
  - Processes bit slice [(k+1)*S-1 : k*S], where S = WIDTH/STAGES, as S/BLK carry-select blocks.
  - Blocks are chained by the select carry; the first block of the slice uses the carry registered by stage k-1 (stage 0 uses cin_eff).
  - Each stage registers: its sum slice, all lower sum slices (delayed), the unprocessed upper operand bits (delayed), the slice carry-out, and a valid bit.
- Final stage outputs:
  - sum: full concatenated result.
  - c_out: carry out of bit WIDTH-1.
  - ovf: carry into MSB XOR carry out of MSB, equivalently (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
- Latency: exactly STAGES cycles from input transfer to out_valid with no stalls. Throughput is 1 result/cycle when out_ready is held at 1.
- Ordering: results emerge in acceptance order; none dropped or duplicated under any out_ready pattern.
- Reset mid-operation clears all in-flight results; the first post-reset result requires a new input transfer.
- Wrap-around: results are modulo 2^WIDTH. Carry appears only on c_out.

Decomposition:
- Shared package csel_pkg:
  - localparam function nblk(WIDTH, BLK).
  - Elaboration check that WIDTH % (BLK*STAGES) == 0; a violation is a fatal error.
- Sub-module csel_block (parameter BLK): inputs a, b, cin; outputs s, cout. Purely combinational; the top generates a chain of them per stage.
- Top holds the handshake, stage valid bits and delay registers only.

Test Plan (WIDTH=32, BLK=4, STAGES=2 unless stated):
- Reset: assert rst_n=0 mid-stream with 2 results in flight -> out_valid=0 and sum=0 immediately; after release, no stale results emerge.
- Add: a=0xFFFF_FFFF, b=0x0000_0001, c_in=0, out_ready=1 -> after 2 cycles sum=0, c_out=1, ovf=0.
- Subtract: sub=1, a=0x8000_0000, b=1 -> sum=0x7FFF_FFFF, c_out=1, ovf=1. Also sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, c_out=0, ovf=0.
- Carry chain across stage boundary: a=0x0000_FFFF, b=0x0000_0001 -> sum=0x0001_0000; c_in=1 with a=0x7FFF_FFFF, b=0 -> sum=0x8000_0000, ovf=1.
- Backpressure: stream 8 random operand pairs at in_valid=1 with out_ready toggling 1,0,0,1,… -> all 8 results match the reference model in order; outputs stable during stalls; in_ready=0 exactly when out_valid=1 and out_ready=0.
- Parameter sweep: WIDTH=16/BLK=4/STAGES=1 (latency 1) and WIDTH=64/BLK=8/STAGES=4 (latency 4) -> 1000 random vectors match a+b+c_in and a-b with correct c_out/ovf; latency measured equals STAGES.

Source files
------------

// File: rtl/csel_pkg.sv
// Shared helpers for the pipelined carry-select adder: block counting and
// the legality rule for WIDTH/BLK/STAGES combinations.
package csel_pkg;

  function automatic int nblk(input int width, input int blk);
    return width / blk;
  endfunction

  function automatic bit cfg_ok(input int width, input int blk, input int stages);
    return (blk > 0) && (stages > 0) && ((width % (blk * stages)) == 0);
  endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select block: two precomputed sums (carry-in 0 and 1) and a
// mux driven by the incoming select carry.
module csel_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           cin,
  output logic [BLK-1:0] s,
  output logic           cout
);

  logic [BLK:0] w_r0;
  logic [BLK:0] w_r1;

  assign w_r0 = {1'b0, a} + {1'b0, b};
  assign w_r1 = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

  assign s    = cin ? w_r1[BLK-1:0] : w_r0[BLK-1:0];
  assign cout = cin ? w_r1[BLK]     : w_r0[BLK];

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor. Stage k adds bit slice k; lower
// result slices and the still-unprocessed upper operand bits ride along.
module csel_adder_pipe
  import csel_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int S  = WIDTH / STAGES;
  localparam int NB = nblk(S, BLK);

  if (!cfg_ok(WIDTH, BLK, STAGES)) begin : g_cfg_check
    $fatal(1, "csel_adder_pipe: WIDTH must be a multiple of BLK*STAGES");
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The whole pipe advances together whenever the output register is empty
  // or being drained, so in_ready is combinational from out_valid/out_ready.
  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub ? 1'b1 : c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IN_W = WIDTH - k * S;

    logic [IN_W-1:0]      w_a;
    logic [IN_W-1:0]      w_b;
    logic                 w_cin;
    logic                 w_vin;
    logic [NB:0]          w_cc;
    logic [S-1:0]         w_slice;
    logic [(k+1)*S-1:0]   w_s_next;
    logic [(k+1)*S-1:0]   r_s;
    logic                 r_c;
    logic                 r_v;

    if (k == 0) begin : g_first
      assign w_a      = a;
      assign w_b      = w_b_eff;
      assign w_cin    = w_cin_eff;
      assign w_vin    = in_valid;
      assign w_s_next = w_slice;
    end else begin : g_next
      assign w_a      = g_stage[k-1].g_fwd.r_a;
      assign w_b      = g_stage[k-1].g_fwd.r_b;
      assign w_cin    = g_stage[k-1].r_c;
      assign w_vin    = g_stage[k-1].r_v;
      assign w_s_next = {w_slice, g_stage[k-1].r_s};
    end

    assign w_cc[0] = w_cin;
    for (genvar j = 0; j < NB; j++) begin : g_blk
      csel_block #(.BLK(BLK)) u_blk (
        .a    (w_a[j*BLK +: BLK]),
        .b    (w_b[j*BLK +: BLK]),
        .cin  (w_cc[j]),
        .s    (w_slice[j*BLK +: BLK]),
        .cout (w_cc[j+1])
      );
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_adv) begin
        r_s <= w_s_next;
        r_c <= w_cc[NB];
        r_v <= w_vin;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IN_W-S-1:0] r_a;
      logic [IN_W-S-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[IN_W-1:S];
          r_b <= w_b[IN_W-1:S];
        end
      end
    end else begin : g_last
      logic r_ovf;

      // Same-sign operands producing a differently-signed result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= (w_a[S-1] == w_b[S-1]) && (w_slice[S-1] != w_a[S-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign sum       = g_stage[STAGES-1].r_s;
  assign c_out     = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Bench for csel_adder_pipe: directed table, backpressure stream, mid-flight
// reset, and random sweeps on 16/4/1 and 64/8/4 configurations.
module tb_csel_adder_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        c;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        c;
    logic        ovf;
  } res_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // main 32/4/2 instance
  logic        in_valid, out_ready, c_in, sub;
  logic [31:0] a, b;
  logic        in_ready, out_valid, c_out, ovf;
  logic [31:0] sum;

  // sweep instances share operands
  logic        s_valid, s_cin, s_sub, s_ready;
  logic [63:0] s_a, s_b;
  logic        ir16, ov16, c16, o16, ir64, ov64, c64, o64;
  logic [15:0] sum16;
  logic [63:0] sum64;

  csel_adder_pipe #(.WIDTH(32), .BLK(4), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  csel_adder_pipe #(.WIDTH(16), .BLK(4), .STAGES(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(ir16),
    .a(s_a[15:0]), .b(s_b[15:0]), .c_in(s_cin), .sub(s_sub), .out_valid(ov16),
    .out_ready(s_ready), .sum(sum16), .c_out(c16), .ovf(o16)
  );

  csel_adder_pipe #(.WIDTH(64), .BLK(8), .STAGES(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(ir64),
    .a(s_a), .b(s_b), .c_in(s_cin), .sub(s_sub), .out_valid(ov64),
    .out_ready(s_ready), .sum(sum64), .c_out(c64), .ovf(o64)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: unsigned arithmetic on w bits; borrow-free subtract means a >= b.
  function automatic res_t ref_model(input logic [63:0] ra, input logic [63:0] rb,
                                     input logic rcin, input logic rsub, input int w);
    logic [64:0] mask, ua, ub, r;
    res_t res;
    mask = (65'd1 << w) - 65'd1;
    ua = {1'b0, ra} & mask;
    ub = {1'b0, rb} & mask;
    if (rsub) begin
      r = ua - ub;
      res.c = (ua >= ub);
    end else begin
      r = ua + ub + {64'd0, rcin};
      res.c = r[w];
    end
    r = r & mask;
    res.sum = r[63:0];
    if (rsub) res.ovf = (ua[w-1] != ub[w-1]) && (r[w-1] != ua[w-1]);
    else      res.ovf = (ua[w-1] == ub[w-1]) && (r[w-1] != ua[w-1]);
    return res;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard queues
  logic [33:0] exp_q[$];
  logic [65:0] exp16_q[$];
  logic [65:0] exp64_q[$];
  int          st16_q[$];
  int          st64_q[$];

  initial begin
    vec_t        vecs[10];
    res_t        r;
    logic [31:0] bp_a[8], bp_b[8];
    logic        bp_cin[8], bp_sub[8];
    logic [33:0] held, e34;
    logic [65:0] e66;
    logic        stalled;
    int          sent, got, cyc, stale, acc, st;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    in_valid = 0; out_ready = 1; c_in = 0; sub = 0; a = '0; b = '0;
    s_valid = 0; s_cin = 0; s_sub = 0; s_ready = 1; s_a = '0; s_b = '0;

    // reset
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_out", {in_ready, out_valid, c_out, ovf, sum}, {1'b1, 3'b000, 32'h0});
    rst_n = 1'b1;

    // directed table, out_ready held high
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = vecs[i].a; b = vecs[i].b; c_in = vecs[i].cin; sub = vecs[i].sub; in_valid = 1;
      @(negedge clk);
      in_valid = 0;
      check($sformatf("vec%0d_early", i), out_valid, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d", i), {out_valid, c_out, ovf, sum},
            {1'b1, vecs[i].c, vecs[i].ovf, vecs[i].sum});
    end

    // backpressure stream, out_ready pattern 1,0,0,1
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = $urandom; bp_b[i] = $urandom;
      bp_cin[i] = 1'($urandom_range(0, 1)); bp_sub[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; cyc = 0; stalled = 0; held = '0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      out_ready = (cyc % 4 == 1) || (cyc % 4 == 0);
      in_valid = (sent < 8);
      if (sent < 8) begin
        a = bp_a[sent]; b = bp_b[sent]; c_in = bp_cin[sent]; sub = bp_sub[sent];
      end
      #1;
      if (stalled) check("bp_hold", {out_valid, c_out, ovf, sum}, {1'b1, held});
      check("bp_in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("bp_extra", 1'b1, 1'b0);
        else begin
          e34 = exp_q.pop_front();
          check($sformatf("bp_res%0d", got), {c_out, ovf, sum}, e34);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        r = ref_model({32'h0, a}, {32'h0, b}, c_in, sub, 32);
        exp_q.push_back({r.c, r.ovf, r.sum[31:0]});
        sent++;
      end
      stalled = out_valid && !out_ready;
      held = {c_out, ovf, sum};
    end
    check("bp_count", got, 8);
    in_valid = 0; out_ready = 1;

    // reset with two results in flight
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; c_in = 0; sub = 0; in_valid = 1;
    @(negedge clk);
    a = 32'h3333_3333; b = 32'h0000_0001;
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    check("inflight_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {out_valid, c_out, ovf, sum}, {3'b000, 32'h0});
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", stale, 0);
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; c_in = 1; sub = 1; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    r = ref_model({32'h0, a}, {32'h0, b}, c_in, sub, 32);
    check("post_rst", {out_valid, c_out, ovf, sum}, {1'b1, r.c, r.ovf, r.sum[31:0]});

    // random sweep on 16/4/1 and 64/8/4, out_ready held high
    acc = 0; cyc = 0;
    while ((acc < 1000 || exp64_q.size() != 0 || exp16_q.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (ov16) begin
        if (exp16_q.size() == 0) check("sw16_extra", 1'b1, 1'b0);
        else begin
          e66 = exp16_q.pop_front(); st = st16_q.pop_front();
          check("sw16_res", {c16, o16, 48'h0, sum16}, e66);
          check("sw16_lat", cyc - st, 1);
        end
      end
      if (ov64) begin
        if (exp64_q.size() == 0) check("sw64_extra", 1'b1, 1'b0);
        else begin
          e66 = exp64_q.pop_front(); st = st64_q.pop_front();
          check("sw64_res", {c64, o64, sum64}, e66);
          check("sw64_lat", cyc - st, 4);
        end
      end
      s_valid = (acc < 1000) && ($urandom_range(0, 4) != 0);
      s_a = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      s_b = ($urandom_range(0, 7) == 0) ? 64'h0000_0000_0000_0001 : {$urandom, $urandom};
      s_cin = 1'($urandom_range(0, 1));
      s_sub = 1'($urandom_range(0, 1));
      if (s_valid) begin
        r = ref_model(s_a, s_b, s_cin, s_sub, 16);
        exp16_q.push_back({r.c, r.ovf, r.sum});
        st16_q.push_back(cyc);
        r = ref_model(s_a, s_b, s_cin, s_sub, 64);
        exp64_q.push_back({r.c, r.ovf, r.sum});
        st64_q.push_back(cyc);
        acc++;
      end
    end
    s_valid = 0;
    check("sweep_count", acc, 1000);
    check("sweep_drained", exp16_q.size() + exp64_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
